// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe.
// The master drives operands and result acceptance. The slave is the adder.
interface cla_adder_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead add/subtract.
// Each stage resolves one GROUP-bit lookahead group and registers its carry for the next stage.
module cla_adder_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input logic             clk,
   input logic             rst,
   cla_adder_pipe_if.slave bus
);
   localparam int unsigned NG = WIDTH / GROUP;

   // Two-level sum-of-products lookahead: c[i+1] = c0&p[0..i] | OR_j g[j]&p[j+1..i]
   function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] p,
                                                  input logic [GROUP-1:0] g,
                                                  input logic             c0);
      logic [GROUP:0] c;
      logic           term;
      c    = '0;
      c[0] = c0;
      for (int unsigned i = 0; i < GROUP; i++) begin
         term = c0;
         for (int unsigned m = 0; m <= i; m++) term = term & p[m];
         c[i+1] = term;
         for (int unsigned j = 0; j <= i; j++) begin
            term = g[j];
            for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return c;
   endfunction

   logic             adv;
   logic             out_v;
   logic             cap_v, cap_c, cap_am, cap_bm;
   logic [WIDTH-1:0] cap_a, cap_b, beff;

   assign out_v        = stg[NG-1].v;
   assign adv          = bus.out_ready | ~out_v;
   assign bus.in_ready = adv;
   assign beff         = bus.b ^ {WIDTH{bus.sub}};

   // Data registers load only with a valid beat so bubbles leave the last result in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_v  <= 1'b0;
         cap_a  <= '0;
         cap_b  <= '0;
         cap_c  <= 1'b0;
         cap_am <= 1'b0;
         cap_bm <= 1'b0;
      end else if (adv) begin
         cap_v <= bus.in_valid;
         if (bus.in_valid) begin
            cap_a  <= bus.a;
            cap_b  <= beff;
            cap_c  <= bus.sub | bus.cin;
            cap_am <= bus.a[WIDTH-1];
            cap_bm <= beff[WIDTH-1];
         end
      end
   end

   for (genvar k = 0; k < NG; k++) begin : stg
      localparam int unsigned LO  = k * GROUP;
      localparam int unsigned REM = WIDTH - LO;

      logic [REM-1:0]   in_a, in_b;
      logic [WIDTH-1:0] in_s, ns, s;
      logic             in_c, in_v, in_am, in_bm;
      logic [GROUP-1:0] p, g;
      logic [GROUP:0]   c;
      logic             v, co, am, bm;

      if (k == 0) begin : src
         assign in_a  = cap_a;
         assign in_b  = cap_b;
         assign in_c  = cap_c;
         assign in_v  = cap_v;
         assign in_s  = '0;
         assign in_am = cap_am;
         assign in_bm = cap_bm;
      end else begin : src
         assign in_a  = stg[k-1].fwd.ra;
         assign in_b  = stg[k-1].fwd.rb;
         assign in_c  = stg[k-1].co;
         assign in_v  = stg[k-1].v;
         assign in_s  = stg[k-1].s;
         assign in_am = stg[k-1].am;
         assign in_bm = stg[k-1].bm;
      end

      assign p = in_a[GROUP-1:0] ^ in_b[GROUP-1:0];
      assign g = in_a[GROUP-1:0] & in_b[GROUP-1:0];
      assign c = cla_carries(p, g, in_c);

      always_comb begin
         ns              = in_s;
         ns[LO +: GROUP] = p ^ c[GROUP-1:0];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v  <= 1'b0;
            s  <= '0;
            co <= 1'b0;
            am <= 1'b0;
            bm <= 1'b0;
         end else if (adv) begin
            v <= in_v;
            if (in_v) begin
               s  <= ns;
               co <= c[GROUP];
               am <= in_am;
               bm <= in_bm;
            end
         end
      end

      // Operand slices still to be summed shrink by one group per stage.
      if (k < NG - 1) begin : fwd
         logic [REM-GROUP-1:0] ra, rb;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ra <= '0;
               rb <= '0;
            end else if (adv && in_v) begin
               ra <= in_a[REM-1:GROUP];
               rb <= in_b[REM-1:GROUP];
            end
         end
      end
   end

   assign bus.out_valid = out_v;
   assign bus.sum       = stg[NG-1].s;
   assign bus.cout      = stg[NG-1].co;
   assign bus.ovf       = (stg[NG-1].am == stg[NG-1].bm) & (stg[NG-1].s[WIDTH-1] != stg[NG-1].am);
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe at WIDTH=16, GROUP=4.
// Expected results come from an integer reference model when a beat is accepted.
module tb_cla_adder_pipe;
   localparam int W  = 16;
   localparam int G  = 4;
   localparam int NG = 4;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        o;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cla_adder_pipe_if #(.WIDTH(W)) bus ();
   cla_adder_pipe #(.WIDTH(W), .GROUP(G)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                  input logic ci, input logic s, input int acc);
      exp_t        e;
      logic [16:0] r;
      int          sr;
      if (s) begin
         r  = {1'b0, aa} + {1'b0, ~bb} + 17'd1;
         sr = int'($signed(aa)) - int'($signed(bb));
      end else begin
         r  = {1'b0, aa} + {1'b0, bb} + {16'd0, ci};
         sr = int'($signed(aa)) + int'($signed(bb)) + (ci ? 1 : 0);
      end
      e.s   = r[15:0];
      e.c   = r[16];
      e.o   = (sr > 32767) || (sr < -32768);
      e.acc = acc;
      return e;
   endfunction

   // Drive one cycle of inputs; retire/push scoreboard entries for the coming edge.
   task automatic drive(input logic iv, input logic [15:0] aa, input logic [15:0] bb,
                        input logic ci, input logic s, input logic ordy, output bit acc);
      bus.in_valid  = iv;
      bus.a         = aa;
      bus.b         = bb;
      bus.cin       = ci;
      bus.sub       = s;
      bus.out_ready = ordy;
      #1;
      if (bus.out_valid && ordy && sb.size() > 0) void'(sb.pop_front());
      acc = iv && bus.in_ready;
      if (acc) sb.push_back(model(aa, bb, ci, s, cyc + 1));
   endtask

   task automatic test_reset();
      bit acc;
      rst = 1'b1;
      drive(0, 16'h0, 16'h0, 0, 0, 0, acc);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_run++; if (bus.sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
      n_run++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
      n_run++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
      n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_wrap();
      bit acc;
      bit got = 0;
      int acc_edge;
      @(negedge clk);
      drive(1, 16'hFFFF, 16'h0001, 0, 0, 1, acc);
      acc_edge = cyc + 1;
      n_run++; if (acc !== 1'b1) begin n_fail++; $display("FAIL wrap_accept: got %b want 1", acc); end
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1;
            n_run++;
            if (cyc - acc_edge !== NG) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", cyc - acc_edge, NG); end
            n_run++;
            if ({bus.sum, bus.cout, bus.ovf} !== {16'h0000, 1'b1, 1'b0}) begin
               n_fail++; $display("FAIL wrap_result: got sum=%h cout=%b ovf=%b want sum=0000 cout=1 ovf=0", bus.sum, bus.cout, bus.ovf);
            end
         end
         drive(0, 16'h0, 16'h0, 0, 0, 1, acc);
      end
      if (!got) begin n_run++; n_fail++; $display("FAIL wrap_timeout: no out_valid within 12 cycles"); end
      sb.delete();
   endtask

   task automatic test_arith();
      logic [15:0] va[$], vb[$];
      logic        vc[$], vs[$];
      int          idx = 0;
      bit          acc;
      va = '{16'h7FFF, 16'h1234, 16'h8000, 16'h0003};
      vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0005};
      vc = '{1'b0, 1'b1, 1'b1, 1'b0};
      vs = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 10; i++) begin
         va.push_back(16'($urandom));
         vb.push_back(16'($urandom));
         vc.push_back(1'($urandom));
         vs.push_back(1'($urandom));
      end
      for (int i = 0; i < 60 && (idx < va.size() || sb.size() > 0); i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               n_run++; n_fail++; $display("FAIL arith_extra: out_valid with nothing expected");
            end else begin
               n_run++;
               if ({bus.sum, bus.cout, bus.ovf} !== {sb[0].s, sb[0].c, sb[0].o}) begin
                  n_fail++; $display("FAIL arith_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                     bus.sum, bus.cout, bus.ovf, sb[0].s, sb[0].c, sb[0].o);
               end
               n_run++;
               if (cyc - sb[0].acc !== NG) begin n_fail++; $display("FAIL arith_latency: got %0d want %0d", cyc - sb[0].acc, NG); end
            end
         end
         if (idx < va.size()) begin
            drive(1, va[idx], vb[idx], vc[idx], vs[idx], 1, acc);
            if (acc) idx++;
         end else drive(0, 16'h0, 16'h0, 0, 0, 1, acc);
      end
      if (idx < va.size() || sb.size() != 0) begin n_run++; n_fail++; $display("FAIL arith_timeout: %0d left to send, %0d pending", va.size() - idx, sb.size()); end
   endtask

   task automatic test_back_to_back();
      int n = 1;
      int prev = -1;
      bit acc;
      for (int i = 0; i < 40 && (n <= 6 || sb.size() > 0); i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               n_run++; n_fail++; $display("FAIL b2b_extra: out_valid with nothing expected");
            end else begin
               n_run++;
               if ({bus.sum, bus.cout, bus.ovf} !== {sb[0].s, sb[0].c, sb[0].o}) begin
                  n_fail++; $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                     bus.sum, bus.cout, bus.ovf, sb[0].s, sb[0].c, sb[0].o);
               end
               n_run++;
               if (cyc - sb[0].acc !== NG) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", cyc - sb[0].acc, NG); end
               if (prev >= 0) begin
                  n_run++;
                  if (cyc !== prev + 1) begin n_fail++; $display("FAIL b2b_gap: result at cycle %0d want %0d", cyc, prev + 1); end
               end
               prev = cyc;
            end
         end
         if (n <= 6) begin
            drive(1, 16'(n), 16'(n * 256), 0, 0, 1, acc);
            if (acc) n++;
         end else drive(0, 16'h0, 16'h0, 0, 0, 1, acc);
      end
      if (n <= 6 || sb.size() != 0) begin n_run++; n_fail++; $display("FAIL b2b_timeout: %0d pending", sb.size()); end
   endtask

   task automatic test_backpressure();
      int          n = 1;
      int          retired = 0;
      int          stall_left = 0;
      bit          started = 0;
      bit          stall_prev = 0;
      logic        ordy;
      logic [18:0] snap = '0;
      bit          acc;
      for (int i = 0; i < 50 && (n <= 6 || sb.size() > 0); i++) begin
         @(negedge clk);
         if (stall_prev) begin
            n_run++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== snap) begin
               n_fail++; $display("FAIL bp_hold: got %h want %h", {bus.out_valid, bus.sum, bus.cout, bus.ovf}, snap);
            end
         end
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               n_run++; n_fail++; $display("FAIL bp_extra: out_valid with nothing expected");
            end else begin
               n_run++;
               if ({bus.sum, bus.cout, bus.ovf} !== {sb[0].s, sb[0].c, sb[0].o}) begin
                  n_fail++; $display("FAIL bp_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                     bus.sum, bus.cout, bus.ovf, sb[0].s, sb[0].c, sb[0].o);
               end
            end
            if (!started && retired == 1) begin
               started    = 1;
               stall_left = 3;
               snap       = {bus.out_valid, bus.sum, bus.cout, bus.ovf};
            end
         end
         ordy = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         stall_prev = !ordy;
         if (n <= 6) begin
            drive(1, 16'(n), 16'(n * 256), 0, 0, ordy, acc);
            if (acc) n++;
         end else drive(0, 16'h0, 16'h0, 0, 0, ordy, acc);
         if (bus.out_valid && ordy) retired++;
         if (!ordy) begin
            n_run++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
         end
      end
      if (n <= 6 || sb.size() != 0) begin n_run++; n_fail++; $display("FAIL bp_timeout: %0d pending", sb.size()); end
      n_run++;
      if (retired !== 6) begin n_fail++; $display("FAIL bp_count: got %0d beats want 6", retired); end
   endtask

   task automatic test_bubbles();
      bit   acc;
      logic exp_v;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         exp_v = (sb.size() > 0) && (cyc == sb[0].acc + NG);
         n_run++;
         if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL bubble_valid: cycle %0d got %b want %b", cyc, bus.out_valid, exp_v); end
         if (bus.out_valid && sb.size() > 0) begin
            n_run++;
            if ({bus.sum, bus.cout, bus.ovf} !== {sb[0].s, sb[0].c, sb[0].o}) begin
               n_fail++; $display("FAIL bubble_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                  bus.sum, bus.cout, bus.ovf, sb[0].s, sb[0].c, sb[0].o);
            end
         end
         if (i < 10 && (i % 2 == 0)) drive(1, 16'($urandom) | 16'h0100, 16'($urandom), 1'($urandom), 1'($urandom), 1, acc);
         else drive(0, 16'h0, 16'h0, 0, 0, 1, acc);
      end
      n_run++;
      if (sb.size() !== 0) begin n_fail++; $display("FAIL bubble_drain: got %0d pending want 0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_reset_midflight();
      bit acc;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1, 16'h4000 + 16'(i), 16'h4000, 1, 0, 1, acc);
      end
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
      n_run++; if (bus.sum !== 16'h0) begin n_fail++; $display("FAIL rstmid_sum: got %h want 0000", bus.sum); end
      n_run++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL rstmid_cout: got %b want 0", bus.cout); end
      n_run++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b want 0", bus.ovf); end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_run++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost: cycle %0d out_valid=%b want 0", cyc, bus.out_valid); end
         drive(0, 16'h0, 16'h0, 0, 0, 1, acc);
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_arith();
      test_back_to_back();
      test_backpressure();
      test_bubbles();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit carry-lookahead adder.
- Splits a WIDTH-bit operand pair into GROUP-bit carry-lookahead groups, one pipeline stage per group. The group carry is registered between stages, which gives one result per clock at WIDTH/GROUP latency.
- Adds an add/subtract mode, a signed-overflow flag and a valid/ready handshake on both sides.
- Sits between operand-producing datapath logic and any result consumer that can back-pressure.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of GROUP and ≥ GROUP.
- GROUP, 4, bits per carry-lookahead group. One pipeline stage per group.
- NG (localparam), WIDTH/GROUP, number of stages. This is also the latency in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in. Ignored when sub=1.
- sub  in  1  0: A+B+cin. 1: A-B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result bits.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, synchronous-style deassert seen at the next clk edge):
  - All stage valid bits, sum, cout and ovf are cleared to 0.
  - out_valid is 0.
  - in_ready is 1 once rst is low.
- Advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - The whole pipeline shifts only when adv=1. When adv=0, every stage register holds.
- Acceptance: a beat is accepted when in_valid & in_ready at the clk edge.
- Operand capture: on acceptance, stage 0 captures the following.
  - Effective B: b ^ {WIDTH{sub}}.
  - Effective carry: sub ? 1 : cin.
  - A, the valid bit, and the MSBs of A and effective B for ovf.
- Group computation: stage k (k = 0..NG-1) computes group k combinationally.
  - Per bit: p = a^b, g = a&b.
  - Internal lookahead carries: c[i+1] = g[i] | p[i]&c[i], flattened to two-level sum-of-products per group.
  - Group sum bits: p ^ c.
- Stage registers: stage k registers the following.
  - Its GROUP sum bits.
  - The group carry-out.
  - The not-yet-consumed upper operand slices.
  - Lower sum bits passed forward unchanged.
- Latency: a beat accepted at edge t has out_valid=1 after edge t+NG, provided adv stayed 1 throughout.
- Throughput: one beat per cycle under continuous in_valid with out_ready=1.
- Bubbles: a stage with valid=0 still shifts. Bubbles are not collapsed and travel through the pipe.
- Outputs: sum, cout and ovf come from the final stage registers.
  - cout = final group carry-out.
  - ovf = (a_msb == beff_msb) & (sum_msb != a_msb).
- Output hold: while out_valid=1 and out_ready=0, sum, cout, ovf and out_valid hold stable and in_ready=0.
- Invalid results: when out_valid=0, sum, cout and ovf retain their last value and must not be relied on.
- Mode and carry timing: sub and cin take effect only on the accepted beat. Changing them mid-flight does not affect beats already in the pipe.
- Simultaneous events:
  - When out_valid & out_ready & in_valid all hold in the same cycle, the output beat retires and a new beat enters stage 0 on the same edge.
  - When rst is asserted mid-operation, all in-flight beats are discarded immediately, with no partial outputs.
- Wrap-around: 0xFFFF+0x0001 wraps to 0x0000 with cout=1. No saturation.
- NG=1 (WIDTH=GROUP): the block degenerates to a single registered CLA with 1-cycle latency. The same handshake applies.

Test Plan (WIDTH=16, GROUP=4, NG=4):
- Wrap-around add: rst pulse, then a=0xFFFF, b=0x0001, cin=0, sub=0, accepted at edge 0, out_ready=1 → out_valid high after edge 4 with sum=0x0000, cout=1, ovf=0. No out_valid before edge 4.
- Signed overflow on add: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Separately, a=0x1234, b=0x0001, cin=1 → sum=0x1236, cout=0, ovf=0.
- Subtract: sub=1, a=0x8000, b=0x0001, cin=1 (ignored) → sum=0x7FFF, cout=1, ovf=1. Separately, sub=1, a=0x0003, b=0x0005 → sum=0xFFFE, cout=0, ovf=0.
- Streaming with back-pressure:
  - Send 6 consecutive beats a=n, b=0x0100·n, n=1..6, out_ready=1 → results 0x0101, 0x0202 … 0x0606 on 6 consecutive cycles starting at edge 4.
  - Repeat with out_ready dropped for 3 cycles while out_valid=1 → in_ready=0 and outputs held stable for those 3 cycles. No beat lost or duplicated, order preserved.
- Bubbles: alternate in_valid 1/0 with out_ready=1 → out_valid alternates, each result exactly 4 cycles after its acceptance.
- Reset mid-flight: accept 3 beats, assert rst asynchronously between edges → out_valid=0, sum=0, cout=0, ovf=0 immediately. After deassertion, in_ready=1 and none of the 3 beats ever appears.
